// File: rtl/cpu_design_params.sv
// Shared rename-stage constants, the free-list FSM encoding and a small helper.
package cpu_design_params;

    localparam int NUM_A_REGS    = 32;
    localparam int NUM_P_REGS    = 64;
    localparam int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS;
    localparam int PRN_WIDTH     = 6;
    localparam int FL_PTR_WIDTH  = $clog2(MAX_FREE_REGS) + 1;

    typedef enum logic [1:0] {
        FL_INIT,
        FL_RUN,
        FL_RECOVER
    } fl_state_t;

    // Number of active lanes in a two-lane valid vector.
    function automatic logic [1:0] lane_count(input logic [1:0] lanes);
        return {1'b0, lanes[0]} + {1'b0, lanes[1]};
    endfunction

endpackage

// File: rtl/fl_ram.sv
// Free-list storage: two write ports at tail / tail+1, two async read ports.
module fl_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 6,
    parameter int IDX_W = 5,
    parameter int BASE  = 32
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             init_we,
    input  logic [1:0]       rel_we,
    input  logic [WIDTH-1:0] rel_prn0,
    input  logic [WIDTH-1:0] rel_prn1,
    input  logic [IDX_W-1:0] rd_idx0,
    input  logic [IDX_W-1:0] rd_idx1,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             we_a;
    logic             we_b;
    logic [WIDTH-1:0] data_a;
    logic [IDX_W-1:0] idx_b;

    // Port A always writes at tail: the init value, lane 0's PRN, or lane 1's
    // PRN when lane 1 releases alone. Port B takes lane 1 only when both push.
    always_comb begin
        we_a   = init_we | (|rel_we);
        we_b   = !init_we && (&rel_we);
        data_a = rel_we[0] ? rel_prn0 : rel_prn1;
        if (init_we) begin
            data_a = WIDTH'(BASE) + WIDTH'(wr_idx);
        end
        idx_b  = wr_idx + IDX_W'(1);
    end

    // Storage write.
    // NOTE: the array has no reset; INIT fills every entry before anything reads it.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[wr_idx] <= data_a;
        end
        if (we_b) begin
            mem[idx_b] <= rel_prn1;
        end
    end

    assign rd_data0 = mem[rd_idx0];
    assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list for rename: self-initialising circular FIFO with
// two-lane in-order allocation, two-lane release and flush restore to chead.
module free_list_ctrl #(
    parameter int NUM_A_REGS    = cpu_design_params::NUM_A_REGS,
    parameter int NUM_P_REGS    = cpu_design_params::NUM_P_REGS,
    parameter int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS,
    parameter int PRN_WIDTH     = cpu_design_params::PRN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           alloc_req,
    output logic [1:0]           alloc_gnt,
    output logic [PRN_WIDTH-1:0] alloc_prn0,
    output logic [PRN_WIDTH-1:0] alloc_prn1,
    input  logic [1:0]           rel_valid,
    input  logic [PRN_WIDTH-1:0] rel_prn0,
    input  logic [PRN_WIDTH-1:0] rel_prn1,
    input  logic [1:0]           commit_alloc_cnt,
    input  logic                 flush,
    output logic                 ready,
    output logic [PRN_WIDTH-1:0] free_count,
    output logic                 err
);

    import cpu_design_params::fl_state_t;
    import cpu_design_params::FL_INIT;
    import cpu_design_params::FL_RUN;
    import cpu_design_params::FL_RECOVER;
    import cpu_design_params::lane_count;

    localparam int               PTR_W    = $clog2(MAX_FREE_REGS) + 1;
    localparam int               IDX_W    = PTR_W - 1;
    localparam logic [PTR_W-1:0] CAPACITY = PTR_W'(MAX_FREE_REGS);

    fl_state_t        state;
    fl_state_t        state_next;

    // Pointers carry one wrap bit above the index so full and empty differ.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] chead;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] chead_next;
    logic             err_next;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] room;
    logic [PTR_W-1:0] gnt_num;
    logic [PTR_W-1:0] rel_num;
    logic [PTR_W-1:0] commit_num;
    logic [PTR_W-1:0] head_granted;
    logic [PTR_W-1:0] in_flight;

    logic [1:0]       gnt;
    logic [1:0]       rel_acc;
    logic             rel_drop;
    logic             init_we;

    logic [PRN_WIDTH-1:0] rd_data0;
    logic [PRN_WIDTH-1:0] rd_data1;

    // Occupancy from registered pointers only, so a release pushed this
    // cycle becomes grantable on the next one.
    assign count        = tail - head;
    assign room         = CAPACITY - count;
    assign gnt_num      = PTR_W'(lane_count(gnt));
    assign rel_num      = PTR_W'(lane_count(rel_acc));
    assign commit_num   = PTR_W'(commit_alloc_cnt);
    assign head_granted = head + gnt_num;
    assign in_flight    = head_granted - chead;
    assign rel_drop     = |(rel_valid & ~rel_acc) && (state != FL_INIT);

    // Grant and release-acceptance decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        gnt     = '0;
        rel_acc = '0;
        if (state == FL_RUN && !flush) begin
            gnt[0] = alloc_req[0] && (count >= PTR_W'(1));
            gnt[1] = alloc_req[1] && gnt[0] && (count >= PTR_W'(2));
        end
        if (state != FL_INIT) begin
            rel_acc[0] = rel_valid[0] && (room >= PTR_W'(1));
            rel_acc[1] = rel_valid[1]
                         && (room >= (rel_acc[0] ? PTR_W'(2) : PTR_W'(1)));
        end
    end

    // Next-state and pointer update: releases, then commit, then flush restore.
    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        chead_next = chead;
        err_next   = err;
        init_we    = 1'b0;

        case (state)
            FL_INIT: begin
                if (tail == CAPACITY) begin
                    state_next = FL_RUN;
                end else begin
                    init_we   = 1'b1;
                    tail_next = tail + PTR_W'(1);
                end
                if (|rel_valid) begin
                    err_next = 1'b1;
                end
            end

            FL_RUN, FL_RECOVER: begin
                head_next = head_granted;
                tail_next = tail + rel_num;
                if (rel_drop) begin
                    err_next = 1'b1;
                end
                // Committing more than is in flight is a protocol error;
                // clamp chead so it never passes head.
                if (commit_num > in_flight) begin
                    err_next   = 1'b1;
                    chead_next = head_granted;
                end else begin
                    chead_next = chead + commit_num;
                end
                if (flush) begin
                    head_next  = chead_next;
                    state_next = FL_RECOVER;
                end else begin
                    state_next = FL_RUN;
                end
            end

            default: begin
                state_next = FL_INIT;
            end
        endcase
    end

    // State, pointers and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FL_INIT;
            head  <= '0;
            tail  <= '0;
            chead <= '0;
            err   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            chead <= chead_next;
            err   <= err_next;
        end
    end

    fl_ram #(
        .DEPTH (MAX_FREE_REGS),
        .WIDTH (PRN_WIDTH),
        .IDX_W (IDX_W),
        .BASE  (NUM_A_REGS)
    ) u_ram (
        .clk      (clk),
        .wr_idx   (tail[IDX_W-1:0]),
        .init_we  (init_we),
        .rel_we   (rel_acc),
        .rel_prn0 (rel_prn0),
        .rel_prn1 (rel_prn1),
        .rd_idx0  (head[IDX_W-1:0]),
        .rd_idx1  (head[IDX_W-1:0] + IDX_W'(1)),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    assign alloc_gnt  = gnt;
    assign alloc_prn0 = rd_data0;
    assign alloc_prn1 = rd_data1;
    assign ready      = (state == FL_RUN);
    assign free_count = PRN_WIDTH'(count);

endmodule
